// File: rtl/mix_engine.sv
// -----------------------------------------------------------------------------
// mix_engine
//   Iterative mixing engine. LANES registers of WIDTH bits are loaded from a
//   seed and then receive one add/xor/shift/multiply round per clock for
//   ROUNDS rounds. Used as a synthetic compute load and as a data scrambler.
//
// Ports
//   clk      in   clock, all state changes on posedge
//   rst_n    in   asynchronous active-low reset
//   start    in   job request (accepted while idle, including the done cycle)
//   abort    in   cancel the running job; lanes keep their current value
//   seed_i   in   LANES*WIDTH initial lanes, lane i = bits [i*WIDTH +: WIDTH]
//   busy     out  job in progress
//   done     out  one-cycle completion pulse
//   round_o  out  rounds completed in the current job
//   state_o  out  lane registers, same packing as seed_i
//   chk_o    out  (only with MIX_ENGINE_CHECKSUM_EN) XOR of all final lanes,
//                 captured with done, unchanged by aborted jobs
//
// Optional feature macro: MIX_ENGINE_CHECKSUM_EN
// -----------------------------------------------------------------------------
module mix_engine #(
  parameter int LANES  = 8,
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LANES*WIDTH-1:0]   seed_i,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         round_o,
  output logic [LANES*WIDTH-1:0]   state_o
`ifdef MIX_ENGINE_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]         chk_o
`endif
);

  localparam int H     = WIDTH / 2;
  localparam int SH_HI = H + 1;
  localparam int SH_LO = (3 * WIDTH) / 8;

  localparam int unsigned MUL_A [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  localparam int unsigned ADD_B [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  localparam int unsigned MUL_C [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
  localparam int unsigned ADD_D [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [LANES*WIDTH-1:0]   lanes;
  logic [LANES*WIDTH-1:0]   mixed;
  logic [CNT_W-1:0]         round_cnt;
  logic                     done_r;
  logic                     last_round;
  logic                     do_load;
  logic                     do_step;
  logic                     do_finish;

  // Lane index i+k wrapped into 0..LANES-1; k is never below -2.
  function automatic int lane(input int i, input int k);
    return (i + k + 8 * LANES) % LANES;
  endfunction

  // One full round. Each step walks the lanes in order and updates in place,
  // so later lanes see already-updated neighbours. Reading o[i] itself before
  // the write gives the pre-step value whenever an offset aliases to i.
  function automatic logic [LANES*WIDTH-1:0] mix_round(input logic [LANES*WIDTH-1:0] s);
    logic [WIDTH-1:0]       o [LANES];
    logic [LANES*WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++) o[i] = s[i*WIDTH +: WIDTH];
    for (int i = 0; i < LANES; i++) o[i] = o[i] + WIDTH'(i);
    for (int i = 0; i < LANES; i++) o[i] = o[i] + o[lane(i, -1)];
    for (int i = 0; i < LANES; i++) o[i] = o[i] + o[lane(i, 1)] - o[lane(i, 5)];
    for (int i = 0; i < LANES; i++) o[i] = o[i] ^ (o[lane(i, 3)] << H);
    for (int i = 0; i < LANES; i++)
      o[i] = o[i] - (o[lane(i, 2)] >> SH_HI) + (o[lane(i, 4)] >> SH_LO);
    for (int i = 0; i < LANES; i++) o[i] = o[i] + o[lane(i, -1)] - o[lane(i, -2)];
    for (int i = 0; i < LANES; i++)
      o[i] = o[i] * WIDTH'(MUL_A[i % 8]) + WIDTH'(ADD_B[i % 8]);
    for (int i = 0; i < LANES; i++)
      o[i] = o[i] * WIDTH'(MUL_C[i % 8]) + WIDTH'(ADD_D[i % 8]);
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = o[i];
    return r;
  endfunction

  assign mixed      = mix_round(lanes);
  assign last_round = (round_cnt == CNT_W'(ROUNDS - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (abort || last_round) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: abort wins over a round step
  always_comb begin
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: do_load = start;
      RUN: begin
        do_step   = !abort;
        do_finish = !abort && last_round;
      end
      default: ;
    endcase
  end

  // Lane registers, round counter, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes     <= '0;
      round_cnt <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= do_finish;
      if (do_load) begin
        lanes     <= seed_i;
        round_cnt <= '0;
      end else if (do_step) begin
        lanes     <= mixed;
        round_cnt <= round_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MIX_ENGINE_CHECKSUM_EN
  function automatic logic [WIDTH-1:0] fold_xor(input logic [LANES*WIDTH-1:0] s);
    logic [WIDTH-1:0] x;
    x = '0;
    for (int i = 0; i < LANES; i++) x = x ^ s[i*WIDTH +: WIDTH];
    return x;
  endfunction

  logic [WIDTH-1:0] chk;

  // Captured from the round result on the edge that raises done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         chk <= '0;
    else if (do_finish) chk <= fold_xor(mixed);
  end

  assign chk_o = chk;
`endif

  assign busy    = (state == RUN);
  assign done    = done_r;
  assign round_o = round_cnt;
  assign state_o = lanes;

endmodule

// File: tb/tb_mix_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_engine
//   Self-checking bench for mix_engine. Three instances:
//     u_small : LANES=1, WIDTH=8,  ROUNDS=1 (table vectors + random seeds)
//     u_big   : LANES=8, WIDTH=32, ROUNDS=4 (jobs, abort, async reset)
//     u_b2b   : LANES=8, WIDTH=32, ROUNDS=2 (start held high, back-to-back)
// -----------------------------------------------------------------------------
module tb_mix_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u_small
  logic        rst_s = 1'b1, start_s = 1'b0, abort_s = 1'b0;
  logic [7:0]  seed_s = '0;
  logic        busy_s, done_s;
  logic [7:0]  round_s, state_s;
  // u_big
  logic         rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0;
  logic [255:0] seed_b = '0;
  logic         busy_b, done_b;
  logic [7:0]   round_b;
  logic [255:0] state_b;
  // u_b2b
  logic         rst_c = 1'b1, start_c = 1'b0, abort_c = 1'b0;
  logic [255:0] seed_c = '0;
  logic         busy_c, done_c;
  logic [7:0]   round_c;
  logic [255:0] state_c;
`ifdef MIX_ENGINE_CHECKSUM_EN
  logic [7:0]   chk_s;
  logic [31:0]  chk_b, chk_c;
  logic [31:0]  last_chk_b = '0;
`endif

  mix_engine #(.LANES(1), .WIDTH(8), .ROUNDS(1), .CNT_W(8)) u_small (
    .clk(clk), .rst_n(rst_s), .start(start_s), .abort(abort_s), .seed_i(seed_s),
    .busy(busy_s), .done(done_s), .round_o(round_s), .state_o(state_s)
`ifdef MIX_ENGINE_CHECKSUM_EN
    , .chk_o(chk_s)
`endif
  );

  mix_engine #(.LANES(8), .WIDTH(32), .ROUNDS(4), .CNT_W(8)) u_big (
    .clk(clk), .rst_n(rst_b), .start(start_b), .abort(abort_b), .seed_i(seed_b),
    .busy(busy_b), .done(done_b), .round_o(round_b), .state_o(state_b)
`ifdef MIX_ENGINE_CHECKSUM_EN
    , .chk_o(chk_b)
`endif
  );

  mix_engine #(.LANES(8), .WIDTH(32), .ROUNDS(2), .CNT_W(8)) u_b2b (
    .clk(clk), .rst_n(rst_c), .start(start_c), .abort(abort_c), .seed_i(seed_c),
    .busy(busy_c), .done(done_c), .round_o(round_c), .state_o(state_c)
`ifdef MIX_ENGINE_CHECKSUM_EN
    , .chk_o(chk_c)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nx(input int i, input int k, input int n);
    return ((i + k) % n + n) % n;
  endfunction

  function automatic logic [255:0] model(input logic [255:0] seed, input int lanes,
                                         input int width, input int rounds);
    longint unsigned o [8];
    longint unsigned mask;
    int unsigned ka [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int unsigned kb [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
    int unsigned kc [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
    int unsigned kd [8] = '{0, 1, 8, 27, 64, 125, 216, 343};
    logic [255:0] r;
    mask = (64'd1 << width) - 64'd1;
    for (int i = 0; i < 8; i++) o[i] = 0;
    for (int i = 0; i < lanes; i++) o[i] = 64'(seed >> (i * width)) & mask;
    for (int rd = 0; rd < rounds; rd++)
      for (int st = 1; st <= 8; st++)
        for (int i = 0; i < lanes; i++) begin
          case (st)
            1: o[i] = o[i] + longint'(i);
            2: o[i] = o[i] + o[nx(i, -1, lanes)];
            3: o[i] = o[i] + o[nx(i, 1, lanes)] - o[nx(i, 5, lanes)];
            4: o[i] = o[i] ^ (o[nx(i, 3, lanes)] << (width / 2));
            5: o[i] = o[i] - (o[nx(i, 2, lanes)] >> (width / 2 + 1))
                           + (o[nx(i, 4, lanes)] >> (3 * width / 8));
            6: o[i] = o[i] + o[nx(i, -1, lanes)] - o[nx(i, -2, lanes)];
            7: o[i] = o[i] * ka[i % 8] + kb[i % 8];
            default: o[i] = o[i] * kc[i % 8] + kd[i % 8];
          endcase
          o[i] = o[i] & mask;
        end
    r = '0;
    for (int i = 0; i < lanes; i++) r = r | (256'(o[i]) << (i * width));
    return r;
  endfunction

  function automatic logic [31:0] xor_lanes(input logic [255:0] v, input int lanes, input int width);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < lanes; i++) x = x ^ (32'(v >> (i * width)) & 32'((64'd1 << width) - 64'd1));
    return x;
  endfunction

  function automatic logic [255:0] rand_seed();
    logic [255:0] s;
    for (int j = 0; j < 8; j++) s[j*32 +: 32] = $urandom();
    return s;
  endfunction

  // One full job on u_big, checked against the model.
  task automatic big_job(input logic [255:0] seed, input string tag);
    logic [255:0] exp;
    int n;
    exp = model(seed, 8, 32, 4);
    seed_b = seed; start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (busy_b && n < 40) begin n++; tick(); end
    check({tag, " busy_cycles"}, 256'(n), 256'd4);
    check({tag, " done"}, done_b, 1'b1);
    check({tag, " state"}, state_b, exp);
    check({tag, " round"}, round_b, 8'd4);
`ifdef MIX_ENGINE_CHECKSUM_EN
    last_chk_b = xor_lanes(exp, 8, 32);
    check({tag, " chk"}, chk_b, last_chk_b);
`endif
    tick();
    check({tag, " done_width"}, done_b, 1'b0);
    check({tag, " state_hold"}, state_b, exp);
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [7:0] exp_state;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [255:0] s, e;
    logic [7:0]   s8, e8;

    vecs[0] = '{seed: 8'h00, exp_state: 8'h06};
    vecs[1] = '{seed: 8'h01, exp_state: 8'h9A};
    vecs[2] = '{seed: 8'hFF, exp_state: 8'h8A};
    vecs[3] = '{seed: 8'h80, exp_state: 8'h06};

    // Asynchronous reset from power-up
    #1; rst_s = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #2;
    check("reset busy", {busy_s, busy_b, busy_c}, 3'b000);
    check("reset done", {done_s, done_b, done_c}, 3'b000);
    check("reset round", {round_s, round_b, round_c}, 24'd0);
    check("reset state_b", state_b, 256'd0);
    check("reset state_s", state_s, 8'd0);
`ifdef MIX_ENGINE_CHECKSUM_EN
    check("reset chk", {chk_s, chk_b, chk_c}, 72'd0);
`endif
    @(posedge clk); #1;
    rst_s = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    check("idle no start busy", busy_s, 1'b0);

    // Table vectors on the 1-lane, 8-bit, 1-round engine
    for (int k = 0; k < 4; k++) begin
      seed_s = vecs[k].seed; start_s = 1'b1; tick(); start_s = 1'b0;
      check($sformatf("vec%0d busy", k), busy_s, 1'b1);
      check($sformatf("vec%0d round0", k), round_s, 8'd0);
      tick();
      check($sformatf("vec%0d done", k), done_s, 1'b1);
      check($sformatf("vec%0d busy_low", k), busy_s, 1'b0);
      check($sformatf("vec%0d state", k), state_s, vecs[k].exp_state);
      check($sformatf("vec%0d round", k), round_s, 8'd1);
`ifdef MIX_ENGINE_CHECKSUM_EN
      check($sformatf("vec%0d chk", k), chk_s, vecs[k].exp_state);
`endif
      tick();
      check($sformatf("vec%0d done_width", k), done_s, 1'b0);
    end

    // Random seeds on the small engine
    for (int k = 0; k < 8; k++) begin
      s8 = 8'($urandom());
      s = model({248'd0, s8}, 1, 8, 1);
      e8 = s[7:0];
      seed_s = s8; start_s = 1'b1; tick(); start_s = 1'b0; tick();
      check($sformatf("rnd_small%0d state", k), state_s, e8);
      check($sformatf("rnd_small%0d done", k), done_s, 1'b1);
      tick();
    end

    // Full jobs on the 8x32, 4-round engine
    for (int j = 0; j < 8; j++) s[j*32 +: 32] = 32'(j);
    big_job(s, "ramp");
    for (int k = 0; k < 3; k++) big_job(rand_seed(), $sformatf("rnd_big%0d", k));

    // Abort after two rounds, then restart from the same seed
    s = rand_seed();
    e = model(s, 8, 32, 2);
    seed_b = s; start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); tick();
    check("abort round_at2", round_b, 8'd2);
    abort_b = 1'b1; tick(); abort_b = 1'b0;
    check("abort busy", busy_b, 1'b0);
    check("abort done", done_b, 1'b0);
    check("abort state", state_b, e);
    check("abort round_hold", round_b, 8'd2);
`ifdef MIX_ENGINE_CHECKSUM_EN
    check("abort chk_hold", chk_b, last_chk_b);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort idle%0d done", k), done_b, 1'b0);
      check($sformatf("abort idle%0d state", k), state_b, e);
    end
    big_job(s, "restart");

    // Asynchronous reset in the middle of a job
    s = rand_seed();
    seed_b = s; start_b = 1'b1; tick(); start_b = 1'b0; tick();
    check("midrst round_at1", round_b, 8'd1);
    #2; rst_b = 1'b0; #1;
    check("midrst busy", busy_b, 1'b0);
    check("midrst done", done_b, 1'b0);
    check("midrst round", round_b, 8'd0);
    check("midrst state", state_b, 256'd0);
`ifdef MIX_ENGINE_CHECKSUM_EN
    check("midrst chk", chk_b, 32'd0);
`endif
    #1; rst_b = 1'b1;
    tick();
    big_job(rand_seed(), "after_rst");

    // start held high on the 2-round engine: done every 3 cycles
    s = rand_seed();
    e = model(s, 8, 32, 2);
    seed_c = s; start_c = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("b2b t%0d done", t), done_c, 1'b1 * ((t % 3) == 0));
      if ((t % 3) == 0) begin
        check($sformatf("b2b t%0d state", t), state_c, e);
        check($sformatf("b2b t%0d round", t), round_c, 8'd2);
`ifdef MIX_ENGINE_CHECKSUM_EN
        check($sformatf("b2b t%0d chk", t), chk_c, xor_lanes(e, 8, 32));
`endif
      end else begin
        check($sformatf("b2b t%0d busy", t), busy_c, 1'b1);
      end
    end
    start_c = 1'b0;
    tick();
    check("b2b stop busy", busy_c, 1'b0);
    check("b2b stop state", state_c, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_engine.md
Name: mix_engine

Overview:
- Parametrised, iterative mixing engine. Applies a fixed add/xor/shift/multiply round to LANES registers of WIDTH bits, one round per clock, for ROUNDS rounds.
- Started by a start/busy/done handshake. A seed vector is loaded at start.
- Used as a synthetic compute-load generator and data scrambler inside simulation and benchmark tops.
- Generalises the hard-wired 8×32-bit free-running mixer to any lane count, width and round count, with load, abort and completion signalling.

Parameters:
- LANES, 8, number of state lanes (≥1).
- WIDTH, 32, bits per lane (≥8, multiple of 8).
- ROUNDS, 2, rounds per job (≥1).
- CNT_W, 8, round-counter width; must satisfy 2^CNT_W > ROUNDS.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled on posedge.
- abort  in  1  cancel running job.
- seed_i  in  LANES*WIDTH  initial lanes; lane i = bits [i*WIDTH +: WIDTH].
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- round_o  out  CNT_W  rounds completed in current job.
- state_o  out  LANES*WIDTH  current lane registers; same packing as seed_i.

Behaviour:
- Reset: rst_n low asynchronously clears busy=0, done=0, round_o=0, state_o=0, FSM=IDLE. Applies mid-job as well; the partial job is discarded.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at an edge: lanes←seed_i, round_o←0, busy←1, go to RUN.
  - start=0: hold.
- RUN, each edge:
  - abort=1 (highest priority): busy←0, done stays 0, lanes hold current value, go to IDLE.
  - Otherwise: lanes←R(lanes), round_o←round_o+1.
  - When this edge completes round ROUNDS: busy←0, done←1 for exactly one cycle, go to IDLE.
- start while in RUN is ignored. start during the done cycle is accepted, allowing back-to-back jobs with no idle bubble.
- Latency: with start sampled at edge 0, rounds are applied at edges 1..ROUNDS. done is high during the cycle after edge ROUNDS. busy is high from after edge 0 through edge ROUNDS.
- state_o holds the final value until the next start. It is directly the lane registers and is not double-buffered.
- Round R: eight sequential in-place steps. Each step visits i=0..LANES-1 in order and uses already-updated lanes. Lane indices are mod LANES. All arithmetic is mod 2^WIDTH, unsigned, logical shifts. H=WIDTH/2.
  - S1: o[i] += i
  - S2: o[i] += o[i-1]
  - S3: o[i] = o[i] + o[i+1] − o[i+5]
  - S4: o[i] ^= o[i+3] << H
  - S5: o[i] = o[i] − (o[i+2] >> (H+1)) + (o[i+4] >> (3*WIDTH/8))
  - S6: o[i] = o[i] + o[i−1] − o[i−2]
  - S7: o[i] = o[i]*A[i%8] + B[i%8], with A={2,3,5,7,11,13,17,19}, B={3,5,7,11,13,17,19,23}
  - S8: o[i] = o[i]*C[i%8] + D[i%8], with C={2,3,3,3,5,13,35,87}, D={0,1,8,27,64,125,216,343}
- Within a step, every operand is read as its value at that point in the sequence. An index that aliases i reads the pre-step value of o[i].
- R is purely combinational; the whole round completes in one cycle.
- Equivalence: LANES=8, WIDTH=32, ROUNDS=2 reproduces exactly one update of the legacy 8-lane mixer.

Optional Feature:
- Macro: MIX_ENGINE_CHECKSUM_EN.
- When defined:
  - Extra output chk_o, out, WIDTH: XOR of all lanes of the final state.
  - Registered on the edge that raises done; reset to 0.
  - Holds until the next done. An aborted job does not update it.
- When undefined: port absent, no checksum logic.

Test Plan:
- LANES=1, WIDTH=8, ROUNDS=1, seed 0x00, start pulse → done one cycle after round edge 1; state_o=0x06; round_o=1; busy low.
- LANES=1, WIDTH=8, ROUNDS=1, seed 0x01 → state_o=0x9A (154). With MIX_ENGINE_CHECKSUM_EN, chk_o=0x9A.
- LANES=8, WIDTH=32, ROUNDS=4, seed o[i]=i → busy high 4 cycles, done pulse exactly 1 cycle. state_o equals the C reference model after 4 rounds; round_o=4.
- Same config, abort asserted at round_o=2 → busy drops next edge, no done, state_o holds the 2-round value. A start 3 cycles later reloads seed and completes normally.
- rst_n pulsed low mid-job at round_o=1 → all outputs 0 immediately, without waiting for clk. After release, start runs a full fresh job.
- start held high continuously, ROUNDS=2 → jobs back-to-back. done pulses every 3 cycles; each job reloads seed_i, so state_o is identical after every job.
